// File: rtl/boot_pkg.sv
// Shared types and constants for the UART serial boot loader.
// Optional feature macro: BOOT_ECHO_EN (command echo and ACK/NAK responses).
package boot_pkg;

  localparam logic [7:0] SYNC_LOAD_DEF = 8'hA5;
  localparam logic [7:0] SYNC_RUN_DEF  = 8'h5A;
  localparam int         TX_GAP_DEF    = 2;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  localparam logic [7:0] UART_STAT = 8'd0;
  localparam logic [7:0] UART_DATA = 8'd1;

  // Main frame parser states
  typedef enum logic [3:0] {
    ST_SYNC, ST_ECHO, ST_ADDR_H, ST_ADDR_L, ST_LEN,
    ST_DATA, ST_CSUM, ST_RESP, ST_RUN
  } boot_state_e;

  // UART bus sequencer states; *_W states are the cycle u_DO is valid
  typedef enum logic [3:0] {
    P_IDLE, P_STAT, P_STAT_W, P_DATA, P_DATA_W, P_CLR, P_CLR_W,
    P_TPOLL, P_TPOLL_W, P_TWR, P_GAP, P_TDONE, P_TDONE_W
  } port_state_e;

endpackage

// File: rtl/boot_uart_port.sv
// Byte-fetch / byte-send bus sequencer toward the UART register file.
// get_ack pulses in the cycle the data byte is on u_DO, so the caller can
// register a RAM write straight from o_rx_byte.
module boot_uart_port
  import boot_pkg::*;
#(
  parameter int TX_GAP = TX_GAP_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_get_req,
  output logic       o_get_ack,
  output logic [7:0] o_rx_byte,
  input  logic       i_put_req,
  input  logic [7:0] i_tx_byte,
  output logic       o_put_ack,
  output logic [7:0] o_AB,
  output logic [7:0] o_DI,
  output logic       o_CS,
  output logic       o_WE,
  input  logic [7:0] i_DO
);

  localparam logic [7:0] GAP_LAST = 8'((TX_GAP > 0) ? TX_GAP - 1 : 0);

  port_state_e r_state, w_next;
  logic [7:0]  r_gap;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= P_IDLE;
    else       r_state <= w_next;
  end

  // Idle-cycle counter after a transmit strobe
  always_ff @(posedge clk) begin
    if (reset)                r_gap <= 8'd0;
    else if (r_state == P_TWR) r_gap <= 8'd0;
    else if (r_state == P_GAP) r_gap <= r_gap + 8'd1;
  end

  // Next state: every strobe state is followed by a sample state
  always_comb begin
    w_next = r_state;
    case (r_state)
      P_IDLE:    if (i_get_req)      w_next = P_STAT;
                 else if (i_put_req) w_next = P_TPOLL;
      P_STAT:    w_next = P_STAT_W;
      P_STAT_W:  w_next = i_DO[0] ? P_DATA : P_STAT;
      P_DATA:    w_next = P_DATA_W;
      P_DATA_W:  w_next = P_CLR;
      P_CLR:     w_next = P_CLR_W;
      // chain straight into the next request to hold 6 cycles per byte
      P_CLR_W:   if (i_get_req)      w_next = P_STAT;
                 else if (i_put_req) w_next = P_TPOLL;
                 else                w_next = P_IDLE;
      P_TPOLL:   w_next = P_TPOLL_W;
      P_TPOLL_W: w_next = i_DO[1] ? P_TPOLL : P_TWR;
      P_TWR:     w_next = (TX_GAP == 0) ? P_TDONE : P_GAP;
      P_GAP:     w_next = (r_gap == GAP_LAST) ? P_TDONE : P_GAP;
      P_TDONE:   w_next = P_TDONE_W;
      P_TDONE_W: w_next = i_DO[1] ? P_TDONE : P_IDLE;
      default:   w_next = P_IDLE;
    endcase
  end

  // Bus strobes and handshake outputs decoded from state
  always_comb begin
    o_CS      = r_state inside {P_STAT, P_DATA, P_CLR, P_TPOLL, P_TWR, P_TDONE};
    o_AB      = (r_state inside {P_DATA, P_TWR}) ? UART_DATA : UART_STAT;
    o_WE      = (r_state == P_TWR);
    o_DI      = (r_state == P_TWR) ? i_tx_byte : 8'd0;
    o_get_ack = (r_state == P_DATA_W);
    o_rx_byte = i_DO;
    o_put_ack = (r_state == P_TDONE_W) && !i_DO[1];
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Serial boot loader: parses load frames from the UART into RAM and holds
// the CPU in reset until the run command. Optional macro BOOT_ECHO_EN adds
// command echo and ACK/NAK responses; without it the loader never writes.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter logic [7:0] SYNC_LOAD = SYNC_LOAD_DEF,
  parameter logic [7:0] SYNC_RUN  = SYNC_RUN_DEF,
  parameter int         TX_GAP    = TX_GAP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  u_AB,
  output logic [7:0]  u_DI,
  input  logic [7:0]  u_DO,
  output logic        u_CS,
  output logic        u_WE,
  output logic [15:0] m_addr,
  output logic [7:0]  m_data,
  output logic        m_we,
  output logic        cpu_reset,
  output logic        boot_done,
  output logic [7:0]  err_count
);

  boot_state_e r_state, w_next;
  logic        w_get_req, w_get_ack, w_put_req, w_put_ack;
  logic [7:0]  w_rx, w_tx;
  logic [7:0]  w_AB, w_DI;
  logic        w_CS, w_WE;
  logic [7:0]  r_cmd, r_sum, r_resp, r_err, r_m_data;
  logic [15:0] r_addr, r_m_addr;
  logic [8:0]  r_rem;
  logic        r_m_we;

  boot_uart_port #(.TX_GAP(TX_GAP)) u_port (
    .clk      (clk),
    .reset    (reset),
    .i_get_req(w_get_req),
    .o_get_ack(w_get_ack),
    .o_rx_byte(w_rx),
    .i_put_req(w_put_req),
    .i_tx_byte(w_tx),
    .o_put_ack(w_put_ack),
    .o_AB     (w_AB),
    .o_DI     (w_DI),
    .o_CS     (w_CS),
    .o_WE     (w_WE),
    .i_DO     (u_DO)
  );

  function automatic boot_state_e dispatch(input logic [7:0] b);
    if (b == SYNC_LOAD)     return ST_ADDR_H;
    else if (b == SYNC_RUN) return ST_RUN;
    else                    return ST_SYNC;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_SYNC;
    else       r_state <= w_next;
  end

  // Next state: advance one field per fetched byte
  always_comb begin
    w_next = r_state;
    case (r_state)
`ifdef BOOT_ECHO_EN
      ST_SYNC:   if (w_get_ack) w_next = ST_ECHO;
`else
      ST_SYNC:   if (w_get_ack) w_next = dispatch(w_rx);
`endif
      ST_ECHO:   if (w_put_ack) w_next = dispatch(r_cmd);
      ST_ADDR_H: if (w_get_ack) w_next = ST_ADDR_L;
      ST_ADDR_L: if (w_get_ack) w_next = ST_LEN;
      ST_LEN:    if (w_get_ack) w_next = ST_DATA;
      ST_DATA:   if (w_get_ack && r_rem == 9'd1) w_next = ST_CSUM;
      ST_CSUM:   if (w_get_ack) w_next = ST_RESP;
`ifdef BOOT_ECHO_EN
      ST_RESP:   if (w_put_ack) w_next = ST_SYNC;
`else
      ST_RESP:   w_next = ST_SYNC;
`endif
      ST_RUN:    w_next = ST_RUN;
      default:   w_next = ST_SYNC;
    endcase
  end

  // Outputs: requests to the sequencer, CPU control, bus parking in RUN
  always_comb begin
    w_get_req = r_state inside {ST_SYNC, ST_ADDR_H, ST_ADDR_L, ST_LEN, ST_DATA, ST_CSUM};
`ifdef BOOT_ECHO_EN
    w_put_req = r_state inside {ST_ECHO, ST_RESP};
`else
    w_put_req = 1'b0;
`endif
    w_tx      = (r_state == ST_ECHO) ? r_cmd : r_resp;
    cpu_reset = (r_state != ST_RUN);
    boot_done = (r_state == ST_RUN);
    err_count = r_err;
    if (r_state == ST_RUN) begin
      u_AB = 8'd0;  u_DI = 8'd0;  u_CS = 1'b0;  u_WE = 1'b0;
      m_addr = 16'd0; m_data = 8'd0; m_we = 1'b0;
    end else begin
      u_AB = w_AB;  u_DI = w_DI;  u_CS = w_CS;  u_WE = w_WE;
      m_addr = r_m_addr; m_data = r_m_data; m_we = r_m_we;
    end
  end

  // Frame datapath: address, remaining count, running sum, RAM write port
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd <= 8'd0;  r_sum <= 8'd0;  r_resp <= 8'd0;  r_err <= 8'd0;
      r_addr <= 16'd0; r_rem <= 9'd0;
      r_m_addr <= 16'd0; r_m_data <= 8'd0; r_m_we <= 1'b0;
    end else begin
      r_m_we <= 1'b0;
      if (w_get_ack) begin
        case (r_state)
          ST_SYNC:   r_cmd <= w_rx;
          ST_ADDR_H: begin r_addr[15:8] <= w_rx; r_sum <= w_rx; end
          ST_ADDR_L: begin r_addr[7:0] <= w_rx;  r_sum <= r_sum + w_rx; end
          ST_LEN: begin
            r_rem <= (w_rx == 8'd0) ? 9'd256 : {1'b0, w_rx};
            r_sum <= r_sum + w_rx;
          end
          ST_DATA: begin
            r_m_addr <= r_addr;
            r_m_data <= w_rx;
            r_m_we   <= 1'b1;
            r_addr   <= r_addr + 16'd1;
            r_rem    <= r_rem - 9'd1;
            r_sum    <= r_sum + w_rx;
          end
          ST_CSUM: begin
            if (w_rx == r_sum) r_resp <= ACK;
            else begin
              r_resp <= NAK;
              if (r_err != 8'hFF) r_err <= r_err + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: a behavioural UART register model feeds byte
// queues, a RAM-write monitor captures m_* traffic, and expectations are
// computed from frame contents with plain 8-bit arithmetic.
module tb_uart_boot_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  u_AB, u_DI, u_DO;
  logic        u_CS, u_WE;
  logic [15:0] m_addr;
  logic [7:0]  m_data;
  logic        m_we, cpu_reset, boot_done;
  logic [7:0]  err_count;

  uart_boot_loader dut (
    .clk(clk), .reset(reset), .u_AB(u_AB), .u_DI(u_DI), .u_DO(u_DO),
    .u_CS(u_CS), .u_WE(u_WE), .m_addr(m_addr), .m_data(m_data), .m_we(m_we),
    .cpu_reset(cpu_reset), .boot_done(boot_done), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;

  // UART model state
  logic [7:0] rx_q[$];
  logic [7:0] tx_log[$];
  int  rx_delay = 0, tx_busy = 0;
  bit  rx_hold = 0;
  bit  rd_pend = 0;
  logic [7:0] rd_val = 8'd0;
  int  last_cs = -10, spacing_bad = 0, n_data = 0, last_data_cyc = -100;
  int  run_strobes = 0, cpu_fall_cyc = -1, mwe_bad = 0;
  logic [1:0] ds_hist = 2'b00;

  // Captured RAM writes and expected traffic
  logic [15:0] wr_addr[$];
  logic [7:0]  wr_data[$];
  logic [15:0] exp_addr[$];
  logic [7:0]  exp_data[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  pl[$];
  int exp_err = 0;

  // UART register model and bus monitor, observed mid-cycle
  always @(negedge clk) begin
    bit ds;
    logic avail;
    cyc++;
    ds = 1'b0;
    rd_pend = 1'b0;
    if (tx_busy > 0) tx_busy--;
    if (rx_delay > 0) rx_delay--;
    avail = (rx_q.size() > 0) && (rx_delay == 0) && !rx_hold;
    if (u_CS === 1'b1) begin
      if (cyc - last_cs < 2) spacing_bad++;
      last_cs = cyc;
      if (boot_done === 1'b1) run_strobes++;
      if (u_WE === 1'b1) begin
        tx_log.push_back(u_DI);
        tx_busy = int'($urandom_range(1, 5));
      end else begin
        rd_pend = 1'b1;
        if (u_AB == 8'd0) rd_val = {6'd0, tx_busy > 0, avail};
        else if (u_AB == 8'd1) begin
          ds = 1'b1;
          n_data++;
          last_data_cyc = cyc;
          rd_val = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hEE;
          rx_delay = int'($urandom_range(0, 3));
        end else rd_val = 8'($urandom);
      end
    end
    if (m_we === 1'b1) begin
      if (!ds_hist[1]) mwe_bad++;
      wr_addr.push_back(m_addr);
      wr_data.push_back(m_data);
    end
    ds_hist = {ds_hist[0], ds};
    if (cpu_reset === 1'b0 && cpu_fall_cyc < 0) cpu_fall_cyc = cyc;
  end

  // UART read data is registered: valid for the cycle after the strobe
  always @(posedge clk) begin
    #1;
    u_DO = rd_pend ? rd_val : 8'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (rx_q.size() > 0 && t < 30000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_timeout"}, t < 30000, 1);
    tick(40);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    rx_q.push_back(b);
`ifdef BOOT_ECHO_EN
    exp_tx.push_back(b);
`endif
  endtask

  task automatic fill_rand(input int len);
    pl.delete();
    for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
  endtask

  // Queue a load frame from pl[]; csum < 0 means send the correct checksum
  task automatic send_load(input logic [15:0] base, input int csum);
    logic [7:0] s, cs;
    int len;
    len = pl.size();
    send_cmd(8'hA5);
    rx_q.push_back(base[15:8]);
    rx_q.push_back(base[7:0]);
    rx_q.push_back(8'(len));
    s = base[15:8] + base[7:0] + 8'(len);
    for (int i = 0; i < len; i++) begin
      rx_q.push_back(pl[i]);
      s = s + pl[i];
      exp_addr.push_back(base + 16'(i));
      exp_data.push_back(pl[i]);
    end
    cs = (csum < 0) ? s : 8'(csum);
    rx_q.push_back(cs);
    if (cs != s && exp_err < 255) exp_err++;
`ifdef BOOT_ECHO_EN
    exp_tx.push_back((cs == s) ? 8'h06 : 8'h15);
`endif
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_nwr"}, wr_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
      chk({tag, "_addr"}, wr_addr[i], exp_addr[i]);
      chk({tag, "_data"}, wr_data[i], exp_data[i]);
    end
    chk({tag, "_err"}, err_count, exp_err);
    chk({tag, "_ntx"}, tx_log.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
      chk({tag, "_tx"}, tx_log[i], exp_tx[i]);
    chk({tag, "_mwe_timing"}, mwe_bad, 0);
    chk({tag, "_spacing"}, spacing_bad, 0);
    chk({tag, "_cpu_rst"}, cpu_reset, 1);
    wr_addr.delete(); wr_data.delete(); exp_addr.delete(); exp_data.delete();
    tx_log.delete(); exp_tx.delete();
  endtask

  initial begin
    int snap;
    logic [7:0] j;
    reset = 1'b1;
    u_DO  = 8'd0;
    tick(3);
    chk("rst_cs", u_CS, 0);
    chk("rst_we", u_WE, 0);
    chk("rst_ab", u_AB, 0);
    chk("rst_di", u_DI, 0);
    chk("rst_mwe", m_we, 0);
    chk("rst_maddr", m_addr, 0);
    chk("rst_mdata", m_data, 0);
    chk("rst_cpu", cpu_reset, 1);
    chk("rst_done", boot_done, 0);
    chk("rst_err", err_count, 0);
    reset = 1'b0;

    // Reference frame, correct then bad checksum
    pl = '{8'hAA, 8'hBB, 8'hCC};
    send_load(16'h1234, -1);
    drain("frameA");
    check_all("frameA");
    pl = '{8'hAA, 8'hBB, 8'hCC};
    send_load(16'h1234, 0);
    drain("frameA_bad");
    check_all("frameA_bad");

    // Address wrap FFFF -> 0000
    pl = '{8'h11, 8'h22};
    send_load(16'hFFFF, -1);
    drain("wrap");
    check_all("wrap");

    // Random frames preceded by junk, random checksum validity
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 2)) begin
        j = 8'($urandom);
        if (j == 8'hA5 || j == 8'h5A) j = 8'h00;
        send_cmd(j);
      end
      fill_rand(int'($urandom_range(1, 8)));
      send_load(16'($urandom), ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, 255)));
      drain("rand");
      check_all("rand");
    end

    // len byte 0 carries 256 payload bytes
    fill_rand(256);
    send_load(16'h8000, -1);
    drain("len256");
    check_all("len256");

    // Status never ready: no data reads, no RAM writes
    rx_hold = 1'b1;
    snap = n_data;
    send_cmd(8'h7E);
    tick(1000);
    chk("hold_nodata", n_data, snap);
    chk("hold_qlen", rx_q.size(), 1);
    rx_hold = 1'b0;
    drain("garbage");
    check_all("garbage");

    // Reset in the middle of a frame header
    send_cmd(8'hA5);
    rx_q.push_back(8'h12);
    drain("partial");
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    exp_err = 0;
    tx_log.delete();
    exp_tx.delete();
    chk("midrst_cpu", cpu_reset, 1);
    chk("midrst_done", boot_done, 0);
    chk("midrst_nwr", wr_addr.size(), 0);
    fill_rand(2);
    send_load(16'h4000, -1);
    drain("after_rst");
    check_all("after_rst");

    // Run command releases the CPU and parks the bus
    send_cmd(8'h5A);
    drain("run");
    chk("run_cpu", cpu_reset, 0);
    chk("run_done", boot_done, 1);
`ifndef BOOT_ECHO_EN
    chk("run_fall_cyc", cpu_fall_cyc - last_data_cyc, 2);
`endif
    chk("run_ntx", tx_log.size(), exp_tx.size());
    rx_q.push_back(8'hA5);
    rx_q.push_back(8'h11);
    rx_q.push_back(8'h22);
    tick(200);
    chk("run_strobes", run_strobes, 0);
    chk("run_qlen", rx_q.size(), 3);
    chk("run_nwr", wr_addr.size(), 0);
    chk("run_cs", u_CS, 0);
    chk("run_maddr", m_addr, 0);
    chk("run_done_hold", boot_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
